biu_arb: RTL and testbench
==========================

BIU_ARB -- requirements
Module: biu_arb

Interface
REQ-001 SHALL have parameter TMO_BITS, default 10: width of the response watchdog counter.
REQ-002 SHALL have port clk  input  1: the single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1: synchronous, active-low (0 = reset), sampled on posedge clk.
REQ-004 SHALL have port ifu_req_pkt_xx  input  `PKT_BITS: fetch request packet, PKT_VLD held by the requester until accepted.
REQ-005 SHALL have port ifu_req_acc  output  1: one-cycle pulse when a fetch beat is forwarded to BIU.
REQ-006 SHALL have port lsu_req_pkt_xx  input  `PKT_BITS: load/store request packet, multi-beat allowed, final beat carries PKT_LAST.
REQ-007 SHALL have port lsu_req_acc  output  1: one-cycle pulse per LSU beat forwarded.
REQ-008 SHALL have port arb_req_pkt_xx  output  `PKT_BITS: the single request channel into BIU.
REQ-009 SHALL have port biu_req_rdy  input  1: BIU accepts the arb_req_pkt_xx beat this cycle when PKT_VLD=1.
REQ-010 SHALL have port biu_resp_pkt_xx  input  `PKT_BITS: BIU response bus, monitored only.
REQ-011 SHALL have port arb_busy  output  1: high whenever state is not ST_IDLE.
REQ-012 SHALL have port arb_owner  output  2: 2'b00 none, 2'b01 IFU, 2'b10 LSU.
REQ-013 SHALL have port arb_tmo  output  1: sticky watchdog error flag.

Function
REQ-014 SHALL implement states ST_IDLE, ST_SEND, ST_WAIT_RESP.
REQ-015 In ST_IDLE, any requester with PKT_VLD=1 SHALL be granted: owner and owner PKT_TYPE registered, next state ST_SEND; grant-to-bus latency is exactly 1 cycle.
REQ-016 With both requesting in ST_IDLE, SHALL grant the requester not granted last (round-robin); the last-granted flag SHALL update on every grant.
REQ-017 In ST_SEND, arb_req_pkt_xx SHALL equal the owner's packet verbatim; all other cycles it SHALL be all-zero.
REQ-018 A beat SHALL be accepted when arb_req PKT_VLD=1 and biu_req_rdy=1; the owner's acc output SHALL pulse in that same cycle and never otherwise.
REQ-019 An accepted beat with PKT_LAST=1 SHALL move to ST_WAIT_RESP; with PKT_LAST=0 SHALL stay in ST_SEND for the next beat.
REQ-020 If the owner drops PKT_VLD in ST_SEND before any beat was accepted, SHALL return to ST_IDLE with no acc pulse; after a beat was accepted, SHALL stay in ST_SEND with PKT_VLD=0 out.
REQ-021 In ST_WAIT_RESP, SHALL return to ST_IDLE the cycle after biu_resp PKT_VLD=1, PKT_LAST=1 and PKT_TYPE equal to the registered owner type; other responses SHALL be ignored.
REQ-022 No new request SHALL be forwarded while in ST_WAIT_RESP, even though the owner still holds PKT_VLD.
REQ-023 The watchdog counter SHALL clear on entry to ST_WAIT_RESP and increment each cycle there; on reaching all-ones it SHALL set arb_tmo and force ST_IDLE.
REQ-024 A matching response in the same cycle the counter reaches all-ones SHALL take priority: arb_tmo not set.
REQ-025 The counter SHALL saturate, never wrap; arb_tmo SHALL clear only by reset.
REQ-026 The requester not owning the bus SHALL see acc=0 and its request SHALL stay pending without loss.

Reset
REQ-027 With reset=0 at a clock edge: state ST_IDLE, owner none, last-granted flag LSU (IFU wins first tie), counter 0, arb_tmo 0.
REQ-028 During reset and the first cycle after it, arb_req_pkt_xx, ifu_req_acc, lsu_req_acc, arb_busy and arb_owner SHALL all be 0.
REQ-029 Reset mid-transaction SHALL abandon it silently: no acc pulse, no bus beat, and a response arriving afterwards ignored.

Verification
REQ-030 IFU line-fetch request at cycle 0, biu_req_rdy=1 -> arb_req VLD and ifu_req_acc at cycle 1, arb_owner=01; FETCH response with LAST at cycle 6 -> arb_busy=0 at cycle 7.
REQ-031 IFU and LSU both request out of reset -> IFU granted; after completion, both still requesting -> LSU granted next.
REQ-032 LSU 2-beat store, biu_req_rdy low 3 cycles -> arb_req held stable, lsu_req_acc pulses exactly twice, then ST_WAIT_RESP.
REQ-033 IFU owner waiting; a non-FETCH response with LAST arrives -> ignored, arb_busy stays 1.
REQ-034 TMO_BITS=4, no response -> arb_tmo=1 after 15 cycles in ST_WAIT_RESP, state ST_IDLE; response on cycle 15 instead -> arb_tmo stays 0.
REQ-035 reset=0 during ST_SEND with biu_req_rdy=1 -> no acc pulse, all outputs 0 next cycle.

Source files
------------

// File: rtl/biu_arb.sv
// Two-requester (IFU/LSU) round-robin arbiter in front of the BIU request channel.
// Tracks ownership until the matching last response arrives or the watchdog expires.

`ifndef PKT_BITS
`define PKT_BITS 40
`endif

module biu_arb #(
    parameter int unsigned TMO_BITS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [`PKT_BITS-1:0] ifu_req_pkt_xx,
    output logic                 ifu_req_acc,
    input  logic [`PKT_BITS-1:0] lsu_req_pkt_xx,
    output logic                 lsu_req_acc,
    output logic [`PKT_BITS-1:0] arb_req_pkt_xx,
    input  logic                 biu_req_rdy,
    input  logic [`PKT_BITS-1:0] biu_resp_pkt_xx,
    output logic                 arb_busy,
    output logic [1:0]           arb_owner,
    output logic                 arb_tmo
);

    // Packet layout: [VLD][LAST][TYPE(2)][payload]
    localparam int unsigned VldBit  = `PKT_BITS - 1;
    localparam int unsigned LastBit = `PKT_BITS - 2;
    localparam int unsigned TypeLsb = `PKT_BITS - 4;

    localparam logic [TMO_BITS-1:0] TmoMax  = '1;
    localparam logic [TMO_BITS-1:0] TmoLast = TmoMax - 1'b1;

    localparam logic [1:0] OwnNone = 2'b00;
    localparam logic [1:0] OwnIfu  = 2'b01;
    localparam logic [1:0] OwnLsu  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RESP
    } state_t;

    state_t              state_q;
    logic [1:0]          owner_q;
    logic [1:0]          own_type_q;
    logic                last_lsu_q;
    logic                beat_seen_q;
    logic [TMO_BITS-1:0] cnt_q;
    logic                tmo_q;

    logic                 ifu_vld;
    logic                 lsu_vld;
    logic                 pick_lsu;
    logic [`PKT_BITS-1:0] owner_pkt;
    logic                 sending;
    logic                 beat_acc;
    logic                 resp_match;
    logic                 unused_resp;

    assign ifu_vld  = ifu_req_pkt_xx[VldBit];
    assign lsu_vld  = lsu_req_pkt_xx[VldBit];
    // Tie goes to whoever was not granted last.
    assign pick_lsu = lsu_vld & (~ifu_vld | ~last_lsu_q);

    assign owner_pkt = owner_q[1] ? lsu_req_pkt_xx : ifu_req_pkt_xx;
    assign sending   = reset & (state_q == ST_SEND);
    assign beat_acc  = sending & owner_pkt[VldBit] & biu_req_rdy;

    assign resp_match = biu_resp_pkt_xx[VldBit] & biu_resp_pkt_xx[LastBit] &
                        (biu_resp_pkt_xx[TypeLsb +: 2] == own_type_q);
    assign unused_resp = ^biu_resp_pkt_xx[TypeLsb-1:0];

    assign arb_req_pkt_xx = sending ? owner_pkt : '0;
    assign ifu_req_acc    = beat_acc & owner_q[0];
    assign lsu_req_acc    = beat_acc & owner_q[1];
    assign arb_busy       = reset & (state_q != ST_IDLE);
    assign arb_owner      = reset ? owner_q : OwnNone;
    assign arb_tmo        = tmo_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OwnNone;
            own_type_q  <= 2'b00;
            last_lsu_q  <= 1'b1;
            beat_seen_q <= 1'b0;
            cnt_q       <= '0;
            tmo_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ifu_vld || lsu_vld) begin
                        state_q     <= ST_SEND;
                        owner_q     <= pick_lsu ? OwnLsu : OwnIfu;
                        own_type_q  <= pick_lsu ? lsu_req_pkt_xx[TypeLsb +: 2]
                                                : ifu_req_pkt_xx[TypeLsb +: 2];
                        last_lsu_q  <= pick_lsu;
                        beat_seen_q <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (beat_acc) begin
                        if (owner_pkt[LastBit]) begin
                            state_q <= ST_WAIT_RESP;
                            cnt_q   <= '0;
                        end else begin
                            beat_seen_q <= 1'b1;
                        end
                    end else if (!owner_pkt[VldBit] && !beat_seen_q) begin
                        // Withdrawn before anything reached the bus.
                        state_q <= ST_IDLE;
                        owner_q <= OwnNone;
                    end
                end
                ST_WAIT_RESP: begin
                    if (resp_match) begin
                        state_q <= ST_IDLE;
                        owner_q <= OwnNone;
                    end else if (cnt_q == TmoLast) begin
                        cnt_q   <= TmoMax;
                        tmo_q   <= 1'b1;
                        state_q <= ST_IDLE;
                        owner_q <= OwnNone;
                    end else if (cnt_q != TmoMax) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    owner_q <= OwnNone;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_biu_arb.sv
// Random-stimulus bench for biu_arb, checked every cycle against a transaction-level model.

`ifndef PKT_BITS
`define PKT_BITS 40
`endif

module tb_biu_arb;

    localparam int TMO    = 4;
    localparam int P      = `PKT_BITS;
    localparam int NCYC   = 4000;
    localparam int TMO_CY = (1 << TMO) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic [P-1:0] ifu_req_pkt_xx;
    logic         ifu_req_acc;
    logic [P-1:0] lsu_req_pkt_xx;
    logic         lsu_req_acc;
    logic [P-1:0] arb_req_pkt_xx;
    logic         biu_req_rdy;
    logic [P-1:0] biu_resp_pkt_xx;
    logic         arb_busy;
    logic [1:0]   arb_owner;
    logic         arb_tmo;

    always #5 clk = ~clk;

    biu_arb #(.TMO_BITS(TMO)) dut (
        .clk             (clk),
        .reset           (reset),
        .ifu_req_pkt_xx  (ifu_req_pkt_xx),
        .ifu_req_acc     (ifu_req_acc),
        .lsu_req_pkt_xx  (lsu_req_pkt_xx),
        .lsu_req_acc     (lsu_req_acc),
        .arb_req_pkt_xx  (arb_req_pkt_xx),
        .biu_req_rdy     (biu_req_rdy),
        .biu_resp_pkt_xx (biu_resp_pkt_xx),
        .arb_busy        (arb_busy),
        .arb_owner       (arb_owner),
        .arb_tmo         (arb_tmo)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [P-1:0] mk(input logic vld, input logic last, input logic [1:0] typ);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return {vld, last, typ, r[P-5:0]};
    endfunction

    // Model: 0 idle, 1 sending, 2 awaiting response. Owner 1 = IFU, 2 = LSU.
    int         m_mode = 0;
    int         m_owner = 0;
    logic [1:0] m_type = 2'b00;
    int         m_beats = 0;
    int         m_wait = 0;
    bit         m_tmo = 0;
    bit         m_last_lsu = 1;

    // Requester state.
    bit         ifu_on = 0;
    logic [P-1:0] ifu_cur = '0;
    bit         lsu_on = 0;
    bit         lsu_gap = 0;
    int         lsu_left = 0;
    int         lsu_sent = 0;
    logic [1:0] lsu_type = 2'b01;
    logic [P-1:0] lsu_cur = '0;

    initial begin
        logic [P-1:0] opkt;
        logic [P-1:0] e_pkt;
        bit e_send, e_acc, e_iacc, e_lacc, win_lsu, ifu_v, lsu_v, match;
        int r;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            reset = (cyc < 2) ? 1'b0 : (($urandom % 150) != 0);
            biu_req_rdy = ($urandom % 10) < 7;
            ifu_req_pkt_xx = ifu_on ? ifu_cur : mk(1'b0, 1'($urandom), 2'($urandom));
            lsu_req_pkt_xx = (lsu_on && !lsu_gap) ? lsu_cur
                                                  : mk(1'b0, 1'($urandom), 2'($urandom));
            r = int'($urandom % 8);
            if (m_mode == 2 && r == 0) biu_resp_pkt_xx = mk(1'b1, 1'b1, m_type);
            else if (r == 1) biu_resp_pkt_xx = mk(1'($urandom), 1'($urandom), 2'($urandom));
            else biu_resp_pkt_xx = '0;
            #1;

            opkt   = (m_owner == 2) ? lsu_req_pkt_xx : ifu_req_pkt_xx;
            e_send = reset && m_mode == 1;
            e_pkt  = e_send ? opkt : '0;
            e_acc  = e_send && opkt[P-1] && biu_req_rdy;
            e_iacc = e_acc && m_owner == 1;
            e_lacc = e_acc && m_owner == 2;

            check("arb_req_pkt", 64'(arb_req_pkt_xx), 64'(e_pkt));
            check("ifu_acc", 64'(ifu_req_acc), 64'(e_iacc));
            check("lsu_acc", 64'(lsu_req_acc), 64'(e_lacc));
            check("busy", 64'(arb_busy), 64'(reset && m_mode != 0));
            check("owner", 64'(arb_owner), (reset && m_mode != 0) ? 64'(m_owner) : 64'd0);
            if (cyc >= 1) check("tmo", 64'(arb_tmo), 64'(m_tmo));

            ifu_v = ifu_req_pkt_xx[P-1];
            lsu_v = lsu_req_pkt_xx[P-1];
            match = biu_resp_pkt_xx[P-1] && biu_resp_pkt_xx[P-2] &&
                    biu_resp_pkt_xx[P-3 -: 2] == m_type;
            if (!reset) begin
                m_mode = 0; m_owner = 0; m_last_lsu = 1; m_tmo = 0;
            end else if (m_mode == 0) begin
                if (ifu_v || lsu_v) begin
                    win_lsu    = lsu_v && (!ifu_v || !m_last_lsu);
                    m_owner    = win_lsu ? 2 : 1;
                    m_type     = win_lsu ? lsu_req_pkt_xx[P-3 -: 2] : ifu_req_pkt_xx[P-3 -: 2];
                    m_last_lsu = win_lsu;
                    m_beats    = 0;
                    m_mode     = 1;
                end
            end else if (m_mode == 1) begin
                if (e_acc) begin
                    if (opkt[P-2]) begin m_mode = 2; m_wait = 0; end
                    else m_beats++;
                end else if (!opkt[P-1] && m_beats == 0) begin
                    m_mode = 0;
                end
            end else begin
                m_wait++;
                if (match) m_mode = 0;
                else if (m_wait == TMO_CY) begin m_tmo = 1; m_mode = 0; end
            end

            if (ifu_on && e_iacc) begin
                ifu_on = ($urandom % 2) == 0;
                if (ifu_on) ifu_cur = mk(1'b1, 1'b1, 2'b00);
            end else if (ifu_on && ($urandom % 64) == 0) begin
                ifu_on = 0;
            end else if (!ifu_on && ($urandom % 3) == 0) begin
                ifu_on = 1;
                ifu_cur = mk(1'b1, 1'b1, 2'b00);
            end

            if (lsu_on && e_lacc) begin
                lsu_left--;
                if (lsu_left == 0) begin
                    lsu_on = 0;
                end else begin
                    lsu_cur = mk(1'b1, lsu_left == 1, lsu_type);
                    lsu_gap = ($urandom % 6) == 0;
                    lsu_sent++;
                end
            end else if (lsu_on && lsu_gap) begin
                lsu_gap = 0;
            end else if (lsu_on && lsu_sent == 0 && ($urandom % 64) == 0) begin
                lsu_on = 0;
            end else if (!lsu_on && ($urandom % 3) == 0) begin
                lsu_left = 1 + int'($urandom % 3);
                lsu_type = (($urandom % 2) == 0) ? 2'b01 : 2'b10;
                lsu_cur  = mk(1'b1, lsu_left == 1, lsu_type);
                lsu_sent = 0;
                lsu_gap  = 0;
                lsu_on   = 1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
